ram_sp_fifo_ctrl: RTL and testbench
===================================

// Module: ram_sp_fifo_ctrl
// PURPOSE
//  FIFO controller that drives a single-port SRAM (default ram_sp_240x32) as its storage.
//  Accepts a 32b valid/ready write stream and returns a 32b valid/ready read stream.
//  The SRAM allows one access per cycle, so write and read requests share the port by arbitration.
//  A 2-entry output prefetch buffer hides the 1-cycle SRAM read latency. Instantiated next to the RAM in a parent wrapper.
// PARAMETERS
//  DEPTH   240  SRAM entries; not required to be a power of 2
//  ADR_WD  8    SRAM address width; 2**ADR_WD >= DEPTH
//  DAT_WD  32   data width
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active-high
//  wr_val_i      in   1       write data valid
//  wr_dat_i      in   DAT_WD  write data
//  wr_rdy_o      out  1       write slot available; transfer occurs when wr_val_i&&wr_rdy_o
//  rd_val_o      out  1       head-of-FIFO data valid
//  rd_dat_o      out  DAT_WD  head data
//  rd_rdy_i      in   1       consumer ready; pop occurs when rd_val_o&&rd_rdy_i
//  cnt_o         out  ADR_WD+1  total held entries (SRAM + in-flight + buffer)
//  ram_adr_o     out  ADR_WD  SRAM address
//  ram_wr_ena_o  out  1       SRAM write enable, active-high
//  ram_wr_dat_o  out  DAT_WD  SRAM write data (= wr_dat_i)
//  ram_rd_ena_o  out  1       SRAM read enable, active-high
//  ram_rd_dat_i  in   DAT_WD  SRAM read data, valid the cycle after ram_rd_ena_o
// BEHAVIOUR
//  Reset: all state is cleared (ptrs, ram_cnt, inflight, buffer, prio_rd).
//   Outputs go low or zero: rd_val_o, rd_dat_o, cnt_o, ram_*_ena_o, wr_rdy_o.
//   An in-flight read is dropped. SRAM contents are not cleared.
//  State:
//   wr_ptr, rd_ptr: 0..DEPTH-1; each wraps DEPTH-1 -> 0.
//   ram_cnt: 0..DEPTH.
//   inflight: 1b, set by a read issued the previous cycle.
//   buf_cnt: 0..2.
//   prio_rd: 1b arbitration flag.
//  Read need:
//   rd_need = (ram_cnt!=0) && (buf_cnt + inflight - pop < 2).
//  Arbitration (at most one SRAM op per cycle):
//   wr_rdy_o = !rst && (ram_cnt!=DEPTH) && !(rd_need && prio_rd). Independent of wr_val_i.
//   rd_sel = rd_need && (prio_rd || !wr_val_i || ram_cnt==DEPTH).
//   wr_sel = wr_val_i && wr_rdy_o && !rd_sel. The two selects are mutually exclusive.
//   prio_rd toggles only when rd_need && wr_val_i && ram_cnt!=DEPTH. This splits bandwidth 1:1 under contention.
//  SRAM drive:
//   ram_rd_ena_o = rd_sel; ram_wr_ena_o = wr_sel.
//   ram_adr_o = rd_sel ? rd_ptr : wr_ptr.
//  Capture: in the cycle after a read, ram_rd_dat_i is written into the buffer tail at the clock edge.
//   This is simultaneous with any pop from the head.
//  rd_val_o = buf_cnt!=0; rd_dat_o = buffer head (registered, no SRAM-to-output comb path).
//  Latency: write accepted in cycle N (FIFO empty, no contention) -> read issued N+1 -> rd_val_o high in N+3.
//  Throughput: 1 read/cycle with no writes; 1 write/cycle with reads idle.
//  ram_cnt: +1 on wr_sel, -1 on rd_sel, never both in one cycle.
//   Full: ram_cnt==DEPTH forces wr_rdy_o=0 while reads drain.
//  cnt_o = ram_cnt + inflight + buf_cnt; maximum DEPTH+2.
//  rd_val_o, once high, holds rd_dat_o stable until popped.
// STRUCTURE
//  Sub-module ram_sp_fifo_pf_buf: 2-entry valid/ready buffer with push, pop and count.
//   Push and pop in the same cycle are allowed at any occupancy the arbiter permits.
//  SRAM (ram_sp_240x32) is instantiated by the parent, not inside this block.
//  Defaults for DEPTH/ADR_WD/DAT_WD go in enc_defines.v as `SP_FIFO_DEPTH/`SP_FIFO_ADR_WD/`SP_FIFO_DAT_WD.
// TESTING (bench uses the ram_sp_240x32 RTL_MODEL)
//  1 Reset, then write 0xA5A5_0001 with rd_rdy_i=1 -> write accepted cycle N; ram_rd_ena_o at N+1; rd_val_o=1, rd_dat_o=0xA5A5_0001 at N+3.
//  2 Write 240 words 0..239 with rd_rdy_i=0 -> reads prefetch 2 entries; 242 accepted; then wr_rdy_o=0, cnt_o=242; ptrs wrap 239->0.
//  3 From full, rd_rdy_i=1 and wr_val_i=1 continuously -> SRAM ops alternate rd/wr; output order 0,1,2..; no loss or duplicate over 1000 words.
//  4 Stream 500 words with rd_rdy_i random 50% and wr_val_i random 70% -> scoreboard exact order; never ram_wr_ena_o&&ram_rd_ena_o.
//  5 Assert rst for 1 cycle while a read is in flight and buffer is full -> next cycle rd_val_o=0, cnt_o=0, wr_rdy_o=1; stale ram_rd_dat_i ignored.
//  6 Empty FIFO, rd_rdy_i=1 -> rd_val_o stays 0; no ram_rd_ena_o; cnt_o=0.

Source files
------------

// File: rtl/ram_sp_fifo_ctrl_pkg.sv
// Shared parameters, state encodings and helpers for the single-port SRAM FIFO controller.
package ram_sp_fifo_ctrl_pkg;

  // Default geometry matching the ram_sp_240x32 macro placed beside the controller.
  localparam int unsigned SP_FIFO_DEPTH  = 240;
  localparam int unsigned SP_FIFO_ADR_WD = 8;
  localparam int unsigned SP_FIFO_DAT_WD = 32;

  // Which requester wins the SRAM port when a read and a write both want it.
  typedef enum logic {
    ARB_WR_FIRST = 1'b0,
    ARB_RD_FIRST = 1'b1
  } arb_prio_e;

  // Occupancy of the 2-entry output prefetch buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_occ_e;

  // Advance a circular pointer, wrapping from the last valid index back to zero.
  // Operates on a 16-bit container so it serves any address width up to 16.
  function automatic logic [15:0] ptr_next(input logic [15:0] ptr, input logic [15:0] last);
    logic [15:0] nxt;
    if (ptr == last) begin
      nxt = 16'd0;
    end else begin
      nxt = ptr + 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ram_sp_fifo_pf_buf.sv
// Two-entry output prefetch buffer. Entry 0 is always the head, so the head data
// comes straight from a flop and never from the SRAM read port.
module ram_sp_fifo_pf_buf
  import ram_sp_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DAT_WD = SP_FIFO_DAT_WD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DAT_WD-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [1:0]        cnt_o,
  output logic              val_o,
  output logic [DAT_WD-1:0] dat_o
);

  buf_occ_e          cnt_q, cnt_d;
  logic [DAT_WD-1:0] ent0_q, ent0_d;
  logic [DAT_WD-1:0] ent1_q, ent1_d;

  // Next-state for the entries: pops shift entry 1 to the head, pushes fill the tail.
  always_comb begin
    cnt_d  = cnt_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case ({push_i, pop_i})
      2'b10: begin
        case (cnt_q)
          BUF_EMPTY: begin
            ent0_d = push_dat_i;
            cnt_d  = BUF_ONE;
          end
          BUF_ONE: begin
            ent1_d = push_dat_i;
            cnt_d  = BUF_TWO;
          end
          default: begin
            // Full with no pop: the arbiter never issues a read that lands here.
            cnt_d = cnt_q;
          end
        endcase
      end
      2'b01: begin
        case (cnt_q)
          BUF_ONE: begin
            cnt_d = BUF_EMPTY;
          end
          BUF_TWO: begin
            ent0_d = ent1_q;
            cnt_d  = BUF_ONE;
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end
      2'b11: begin
        case (cnt_q)
          BUF_EMPTY: begin
            // Pop of an empty buffer is not a real transfer; keep the push.
            ent0_d = push_dat_i;
            cnt_d  = BUF_ONE;
          end
          BUF_ONE: begin
            ent0_d = push_dat_i;
            cnt_d  = BUF_ONE;
          end
          BUF_TWO: begin
            ent0_d = ent1_q;
            ent1_d = push_dat_i;
            cnt_d  = BUF_TWO;
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Buffer state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= BUF_EMPTY;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign cnt_o = cnt_q;
  assign val_o = (cnt_q != BUF_EMPTY);
  assign dat_o = ent0_q;

endmodule

// File: rtl/ram_sp_fifo_ctrl.sv
// FIFO controller using an external single-port SRAM as storage. Reads and writes
// share the single SRAM port; a 2-entry prefetch buffer hides the read latency.
module ram_sp_fifo_ctrl
  import ram_sp_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = SP_FIFO_DEPTH,
  parameter int unsigned ADR_WD = SP_FIFO_ADR_WD,
  parameter int unsigned DAT_WD = SP_FIFO_DAT_WD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_val_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  output logic              wr_rdy_o,
  output logic              rd_val_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  input  logic              rd_rdy_i,
  output logic [ADR_WD:0]   cnt_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  localparam logic [ADR_WD:0]   DEPTH_CNT = (ADR_WD+1)'(DEPTH);
  localparam logic [ADR_WD-1:0] LAST_PTR  = ADR_WD'(DEPTH - 1);

  logic [ADR_WD-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADR_WD-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADR_WD:0]   ram_cnt_q, ram_cnt_d;
  logic              inflight_q, inflight_d;
  arb_prio_e         prio_rd_q, prio_rd_d;

  logic [1:0]        pf_cnt_s;
  logic              pf_val_s;
  logic [DAT_WD-1:0] pf_dat_s;
  logic              pop_s;
  logic              ram_empty_s;
  logic              ram_full_s;
  logic [2:0]        occ_s;
  logic [2:0]        occ_lim_s;
  logic              rd_need_s;
  logic              rd_sel_s;
  logic              wr_sel_s;
  logic              wr_rdy_s;

  assign pop_s = pf_val_s & rd_rdy_i;

  // Arbitration: decide whether the SRAM port does a prefetch read, a write, or nothing.
  always_comb begin
    ram_empty_s = (ram_cnt_q == '0);
    ram_full_s  = (ram_cnt_q == DEPTH_CNT);
    // Entries already in or heading for the buffer, minus the one leaving this cycle.
    occ_s       = {1'b0, pf_cnt_s} + {2'b00, inflight_q};
    occ_lim_s   = 3'd2 + {2'b00, pop_s};
    if (!ram_empty_s && (occ_s < occ_lim_s)) begin
      rd_need_s = 1'b1;
    end else begin
      rd_need_s = 1'b0;
    end
    wr_rdy_s = !rst && !ram_full_s && !(rd_need_s && (prio_rd_q == ARB_RD_FIRST));
    rd_sel_s = !rst && rd_need_s &&
               ((prio_rd_q == ARB_RD_FIRST) || !wr_val_i || ram_full_s);
    wr_sel_s = wr_val_i && wr_rdy_s && !rd_sel_s;
  end

  // Next-state for pointers, SRAM occupancy, the in-flight flag and the priority toggle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = rd_sel_s;
    prio_rd_d  = prio_rd_q;

    if (wr_sel_s) begin
      wr_ptr_d = ADR_WD'(ptr_next(16'(wr_ptr_q), 16'(LAST_PTR)));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_sel_s) begin
      rd_ptr_d = ADR_WD'(ptr_next(16'(rd_ptr_q), 16'(LAST_PTR)));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_sel_s, rd_sel_s})
      2'b10:   ram_cnt_d = ram_cnt_q + {{ADR_WD{1'b0}}, 1'b1};
      2'b01:   ram_cnt_d = ram_cnt_q - {{ADR_WD{1'b0}}, 1'b1};
      default: ram_cnt_d = ram_cnt_q;
    endcase

    // Flip priority only when both sides genuinely compete, giving a 1:1 split.
    if (rd_need_s && wr_val_i && !ram_full_s) begin
      if (prio_rd_q == ARB_RD_FIRST) begin
        prio_rd_d = ARB_WR_FIRST;
      end else begin
        prio_rd_d = ARB_RD_FIRST;
      end
    end else begin
      prio_rd_d = prio_rd_q;
    end
  end

  // Controller state register; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      prio_rd_q  <= ARB_WR_FIRST;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      prio_rd_q  <= prio_rd_d;
    end
  end

  // SRAM read data arrives one cycle after the read and is pushed into the buffer tail.
  ram_sp_fifo_pf_buf #(
    .DAT_WD(DAT_WD)
  ) u_pf_buf (
    .clk       (clk),
    .rst       (rst),
    .push_i    (inflight_q),
    .push_dat_i(ram_rd_dat_i),
    .pop_i     (pop_s),
    .cnt_o     (pf_cnt_s),
    .val_o     (pf_val_s),
    .dat_o     (pf_dat_s)
  );

  assign wr_rdy_o     = wr_rdy_s;
  assign rd_val_o     = pf_val_s;
  assign rd_dat_o     = pf_dat_s;
  assign ram_rd_ena_o = rd_sel_s;
  assign ram_wr_ena_o = wr_sel_s;
  assign ram_adr_o    = rd_sel_s ? rd_ptr_q : wr_ptr_q;
  assign ram_wr_dat_o = wr_dat_i;
  assign cnt_o        = ram_cnt_q
                      + {{(ADR_WD-1){1'b0}}, pf_cnt_s}
                      + {{ADR_WD{1'b0}}, inflight_q};

endmodule

// File: tb/tb_ram_sp_fifo_ctrl.sv
// Self-checking bench: behavioural SRAM beside the controller, queue-based FIFO model.
module tb_ram_sp_fifo_ctrl;
  import ram_sp_fifo_ctrl_pkg::*;

  localparam int DEPTH  = 240;
  localparam int ADR_WD = 8;
  localparam int DAT_WD = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_val_i;
  logic [DAT_WD-1:0] wr_dat_i;
  logic              wr_rdy_o;
  logic              rd_val_o;
  logic [DAT_WD-1:0] rd_dat_o;
  logic              rd_rdy_i;
  logic [ADR_WD:0]   cnt_o;
  logic [ADR_WD-1:0] ram_adr_o;
  logic              ram_wr_ena_o;
  logic [DAT_WD-1:0] ram_wr_dat_o;
  logic              ram_rd_ena_o;
  logic [DAT_WD-1:0] ram_rd_dat;

  always #5 clk = ~clk;

  ram_sp_fifo_ctrl #(
    .DEPTH (DEPTH),
    .ADR_WD(ADR_WD),
    .DAT_WD(DAT_WD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_val_i    (wr_val_i),
    .wr_dat_i    (wr_dat_i),
    .wr_rdy_o    (wr_rdy_o),
    .rd_val_o    (rd_val_o),
    .rd_dat_o    (rd_dat_o),
    .rd_rdy_i    (rd_rdy_i),
    .cnt_o       (cnt_o),
    .ram_adr_o   (ram_adr_o),
    .ram_wr_ena_o(ram_wr_ena_o),
    .ram_wr_dat_o(ram_wr_dat_o),
    .ram_rd_ena_o(ram_rd_ena_o),
    .ram_rd_dat_i(ram_rd_dat)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [DAT_WD-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_wr_ena_o && (ram_adr_o < ADR_WD'(DEPTH))) mem[ram_adr_o] <= ram_wr_dat_o;
    if (ram_rd_ena_o && (ram_adr_o < ADR_WD'(DEPTH))) ram_rd_dat <= mem[ram_adr_o];
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] q[$];
  logic        s_rd_val, s_rd_ena, s_wr_ena, s_wr_rdy, s_fire_w, s_fire_r;
  logic [31:0] s_rd_dat;
  logic [8:0]  s_cnt;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: sample at negedge, check against the model, apply the edge's transfers.
  task automatic tick();
    @(negedge clk);
    s_rd_val = rd_val_o;
    s_rd_dat = rd_dat_o;
    s_rd_ena = ram_rd_ena_o;
    s_wr_ena = ram_wr_ena_o;
    s_wr_rdy = wr_rdy_o;
    s_cnt    = cnt_o;
    s_fire_w = wr_val_i && wr_rdy_o;
    s_fire_r = rd_val_o && rd_rdy_i;
    if (rst) begin
      check_eq("rst_wr_rdy", 64'(wr_rdy_o), 64'd0);
      check_eq("rst_rd_ena", 64'(ram_rd_ena_o), 64'd0);
      check_eq("rst_wr_ena", 64'(ram_wr_ena_o), 64'd0);
      q.delete();
      s_fire_w = 1'b0;
      s_fire_r = 1'b0;
    end else begin
      check_eq("cnt", 64'(cnt_o), 64'(q.size()));
      check_eq("excl", 64'(ram_wr_ena_o & ram_rd_ena_o), 64'd0);
      if (ram_rd_ena_o || ram_wr_ena_o) check_eq("adr_rng", 64'(ram_adr_o < ADR_WD'(DEPTH)), 64'd1);
      if (q.size() == 0) check_eq("val_empty", 64'(rd_val_o), 64'd0);
      else if (rd_val_o) check_eq("rd_dat", 64'(rd_dat_o), 64'(q[0]));
      if (q.size() >= DEPTH + 2) check_eq("full_rdy", 64'(wr_rdy_o), 64'd0);
      if (s_fire_r && (q.size() != 0)) void'(q.pop_front());
      if (s_fire_w) q.push_back(wr_dat_i);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, pops, rd_ops, wr_ops, cyc, wrote, diff;
    logic found;
    rst = 1'b1; wr_val_i = 1'b0; wr_dat_i = 32'd0; rd_rdy_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_rdy", 64'(s_wr_rdy), 64'd1);
    check_eq("rst_val", 64'(s_rd_val), 64'd0);
    check_eq("rst_dat", 64'(s_rd_dat), 64'd0);
    check_eq("rst_cnt", 64'(s_cnt), 64'd0);

    // 1: single-word latency
    wr_val_i = 1'b1; wr_dat_i = 32'hA5A5_0001; rd_rdy_i = 1'b1;
    tick();
    check_eq("t1_acc", 64'(s_fire_w), 64'd1);
    wr_val_i = 1'b0;
    tick();
    check_eq("t1_rd_ena", 64'(s_rd_ena), 64'd1);
    tick();
    check_eq("t1_val_n2", 64'(s_rd_val), 64'd0);
    tick();
    check_eq("t1_val_n3", 64'(s_rd_val), 64'd1);
    check_eq("t1_dat", 64'(s_rd_dat), 64'h0000_0000_A5A5_0001);

    // 6: empty FIFO stays idle
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t6_rd_ena", 64'(s_rd_ena), 64'd0);
      check_eq("t6_val", 64'(s_rd_val), 64'd0);
    end

    // 2: fill to full with no consumer
    rd_rdy_i = 1'b0; wr_val_i = 1'b1; wr_dat_i = 32'd0; acc = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (s_fire_w) begin
        acc++;
        wr_dat_i = 32'(acc);
      end
    end
    check_eq("t2_acc", 64'(acc), 64'd242);
    check_eq("t2_cnt", 64'(cnt_o), 64'd242);
    check_eq("t2_rdy", 64'(wr_rdy_o), 64'd0);

    // 3: from full, continuous read and write contention
    rd_rdy_i = 1'b1; pops = 0; rd_ops = 0; wr_ops = 0; cyc = 0;
    while (pops < 1000 && cyc < 5000) begin
      tick();
      cyc++;
      if (s_fire_r) pops++;
      if (s_rd_ena) rd_ops++;
      if (s_wr_ena) wr_ops++;
      if (s_fire_w) begin
        acc++;
        wr_dat_i = 32'(acc);
      end
    end
    check_eq("t3_pops", 64'(pops), 64'd1000);
    diff = (rd_ops > wr_ops) ? (rd_ops - wr_ops) : (wr_ops - rd_ops);
    check_eq("t3_balance", 64'(diff <= 4), 64'd1);

    // 4: random valid/ready traffic
    wrote = 0; cyc = 0; wr_dat_i = $urandom;
    while (wrote < 500 && cyc < 5000) begin
      wr_val_i = ($urandom_range(99) < 70);
      rd_rdy_i = ($urandom_range(1) == 1);
      tick();
      cyc++;
      if (s_fire_w) begin
        wrote++;
        wr_dat_i = $urandom;
      end
    end
    check_eq("t4_wrote", 64'(wrote), 64'd500);
    wr_val_i = 1'b0; rd_rdy_i = 1'b1; cyc = 0;
    while (q.size() != 0 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_eq("t4_drain", 64'(q.size()), 64'd0);

    // 5: reset with a read in flight and data buffered
    wr_val_i = 1'b1; rd_rdy_i = 1'b0; wr_dat_i = 32'h5A5A_0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_fire_w) wr_dat_i = wr_dat_i + 32'd1;
    end
    wr_val_i = 1'b0; rd_rdy_i = 1'b1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_rd_ena && s_rd_val) found = 1'b1;
    end
    check_eq("t5_found", 64'(found), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("t5_val", 64'(s_rd_val), 64'd0);
    check_eq("t5_cnt", 64'(s_cnt), 64'd0);
    check_eq("t5_rdy", 64'(s_wr_rdy), 64'd1);
    tick();
    check_eq("t5_stale", 64'(s_rd_val), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
